// File: rtl/normalize_control_pkg.sv
// Shared floating-point constants, shift-selector encoding and controller
// state type for the normalization path.
package normalize_control_pkg;

  localparam int MANT_W     = 29;
  localparam int EXP_W      = 8;
  localparam int HIDDEN_BIT = 27;

  localparam logic [EXP_W-1:0] EXP_MAX    = EXP_W'(2**EXP_W - 1);
  localparam logic [EXP_W-1:0] EXP_OVF_TH = EXP_W'(2**EXP_W - 2);
  localparam logic [EXP_W-1:0] EXP_ONE    = EXP_W'(1);

  localparam logic [1:0] SEL_HOLD  = 2'd0;
  localparam logic [1:0] SEL_RIGHT = 2'd1;
  localparam logic [1:0] SEL_LEFT  = 2'd2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/normalize_control_left_right.sv
// One-position left/right mantissa shifter steered by the normalize selector.
module normalize_control_left_right
  import normalize_control_pkg::*;
(
  input  logic [MANT_W-1:0] m,
  input  logic [1:0]        sel,
  output logic [MANT_W-1:0] m_next
);

  // Unused selector code 3 behaves as hold so the shifter never corrupts M.
  always_comb begin
    m_next = m;
    case (sel)
      SEL_RIGHT: m_next = {1'b0, m[MANT_W-1:1]};
      SEL_LEFT:  m_next = {m[MANT_W-2:0], 1'b0};
      default:   m_next = m;
    endcase
  end

endmodule

// File: rtl/normalize_control.sv
// Sequential mantissa normalizer: one shift per cycle until the leading one
// reaches the hidden-bit position, with exponent adjust and zero/ovf/unf flags.
module normalize_control
  import normalize_control_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [MANT_W-1:0] mantissa_in,
  input  logic [EXP_W-1:0]  exponent_in,
  output logic [1:0]        normalize_selector,
  output logic              busy,
  output logic              done,
  output logic [MANT_W-1:0] mantissa_out,
  output logic [EXP_W-1:0]  exponent_out,
  output logic              zero,
  output logic              overflow,
  output logic              underflow
);

  state_t            state;
  logic [MANT_W-1:0] m_q;
  logic [EXP_W-1:0]  e_q;
  logic [MANT_W-1:0] m_next;
  logic              carry_set;
  logic              hidden_set;

  assign carry_set  = m_q[MANT_W-1];
  assign hidden_set = m_q[HIDDEN_BIT];

  // A shift is requested only when the current cycle will not finish, so the
  // selector naturally reads hold on the finishing cycle and in IDLE.
  always_comb begin
    normalize_selector = SEL_HOLD;
    if (state == RUN && m_q != '0) begin
      if (carry_set) begin
        if (e_q < EXP_OVF_TH) normalize_selector = SEL_RIGHT;
      end else if (!hidden_set && e_q > EXP_ONE) begin
        normalize_selector = SEL_LEFT;
      end
    end
  end

  normalize_control_left_right u_shifter (
    .m      (m_q),
    .sel    (normalize_selector),
    .m_next (m_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      m_q          <= '0;
      e_q          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      mantissa_out <= '0;
      exponent_out <= '0;
      zero         <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            m_q       <= mantissa_in;
            e_q       <= exponent_in;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (normalize_selector == SEL_RIGHT) begin
            m_q <= m_next;
            e_q <= e_q + EXP_ONE;
          end else if (normalize_selector == SEL_LEFT) begin
            m_q <= m_next;
            e_q <= e_q - EXP_ONE;
          end else begin
            // Finishing cycle: classify the terminal condition and latch results.
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
            if (m_q == '0) begin
              zero         <= 1'b1;
              e_q          <= '0;
              mantissa_out <= '0;
              exponent_out <= '0;
            end else if (carry_set) begin
              overflow     <= 1'b1;
              m_q          <= {1'b0, m_q[MANT_W-1:1]};
              e_q          <= EXP_MAX;
              mantissa_out <= {1'b0, m_q[MANT_W-1:1]};
              exponent_out <= EXP_MAX;
            end else if (hidden_set) begin
              mantissa_out <= m_q;
              exponent_out <= e_q;
            end else begin
              underflow    <= 1'b1;
              mantissa_out <= m_q;
              exponent_out <= e_q;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
